// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller for single-port SRAM macros with a BIST port.
// Drives the macro BIST_* pins, checks every read one cycle later and keeps first-fail diagnostics.
module sram_march_bist_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [2:0]        fail_elem_o,
    output logic [DATA_W-1:0] fail_bits_o,
    output logic [7:0]        fail_cnt_o,
    output logic              bist_en_o,
    output logic              bist_men_o,
    output logic              bist_wen_o,
    output logic              bist_ren_o,
    output logic [ADDR_W-1:0] bist_addr_o,
    output logic [DATA_W-1:0] bist_din_o,
    output logic [DATA_W-1:0] bist_bm_o,
    input  logic [DATA_W-1:0] bist_dout_i,
    output logic [1:0]        dbg_state_o
);
    // Handshake: start_i is a level request sampled only in IDLE; the request is
    // taken at the edge where busy_o rises, and done_o pulses once before busy_o falls.
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ONES = '1;

    state_t            state;
    logic [2:0]        elem;
    logic              cmp_valid;
    logic [DATA_W-1:0] cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;
    logic [2:0]        cmp_elem;
    logic [DATA_W-1:0] diff;
    logic              miscmp;
    logic              up, at_end, run_end, n_rd;
    logic [2:0]        n_elem;
    logic [ADDR_W-1:0] n_addr;
    logic [DATA_W-1:0] n_din;

    assign dbg_state_o = state;
    assign diff        = bist_dout_i ^ cmp_exp;
    assign miscmp      = cmp_valid && (diff != '0);

    // Next operation derived from the operation currently on the pins.
    always_comb begin
        n_elem  = elem;
        n_addr  = bist_addr_o;
        n_rd    = 1'b0;
        run_end = 1'b0;
        up      = (elem != 3'd3) && (elem != 3'd4);
        at_end  = up ? (bist_addr_o == LAST) : (bist_addr_o == '0);
        if (bist_ren_o && elem != 3'd5) begin
            n_rd = 1'b0;
        end else if (at_end) begin
            run_end = (elem == 3'd5);
            n_elem  = elem + 3'd1;
            n_rd    = 1'b1;
            n_addr  = (elem == 3'd2 || elem == 3'd3) ? LAST : '0;
        end else begin
            n_addr = up ? bist_addr_o + 1'b1 : bist_addr_o - 1'b1;
            n_rd   = (elem != 3'd0);
        end
        n_din = (!n_rd && (n_elem == 3'd1 || n_elem == 3'd3)) ? ONES : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            elem        <= '0;
            cmp_valid   <= 1'b0;
            cmp_exp     <= '0;
            cmp_addr    <= '0;
            cmp_elem    <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_addr_o <= '0;
            fail_elem_o <= '0;
            fail_bits_o <= '0;
            fail_cnt_o  <= '0;
            bist_en_o   <= 1'b0;
            bist_men_o  <= 1'b0;
            bist_wen_o  <= 1'b0;
            bist_ren_o  <= 1'b0;
            bist_addr_o <= '0;
            bist_din_o  <= '0;
            bist_bm_o   <= '0;
        end else begin
            done_o    <= 1'b0;
            cmp_valid <= (state == RUN) && bist_ren_o;
            cmp_exp   <= (elem == 3'd2 || elem == 3'd4) ? ONES : '0;
            cmp_addr  <= bist_addr_o;
            cmp_elem  <= elem;
            if (miscmp) begin
                if (fail_cnt_o == '0) begin
                    fail_addr_o <= cmp_addr;
                    fail_elem_o <= cmp_elem;
                    fail_bits_o <= diff;
                end
                if (fail_cnt_o != 8'hFF) fail_cnt_o <= fail_cnt_o + 8'd1;
            end
            case (state)
                IDLE: if (start_i) begin
                    state       <= RUN;
                    elem        <= '0;
                    busy_o      <= 1'b1;
                    pass_o      <= 1'b0;
                    fail_o      <= 1'b0;
                    fail_addr_o <= '0;
                    fail_elem_o <= '0;
                    fail_bits_o <= '0;
                    fail_cnt_o  <= '0;
                    bist_en_o   <= 1'b1;
                    bist_bm_o   <= ONES;
                    bist_men_o  <= 1'b1;
                    bist_wen_o  <= 1'b1;
                    bist_ren_o  <= 1'b0;
                    bist_addr_o <= '0;
                    bist_din_o  <= '0;
                end
                RUN: begin
                    elem        <= n_elem;
                    bist_addr_o <= n_addr;
                    bist_din_o  <= n_din;
                    bist_men_o  <= !run_end;
                    bist_ren_o  <= n_rd && !run_end;
                    bist_wen_o  <= !n_rd && !run_end;
                    if (run_end) state <= DRAIN;
                end
                DRAIN: begin
                    // The final E5 compare resolves in this cycle, so fold it in here.
                    state  <= DONE;
                    done_o <= 1'b1;
                    pass_o <= !miscmp && (fail_cnt_o == '0);
                    fail_o <= miscmp || (fail_cnt_o != '0);
                end
                DONE: begin
                    state       <= IDLE;
                    busy_o      <= 1'b0;
                    bist_en_o   <= 1'b0;
                    bist_bm_o   <= '0;
                    bist_addr_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_march_bist_ctrl.sv
// Bench for sram_march_bist_ctrl: two instances (256 and 5 words) on behavioural SRAM models
// with stuck-at and read-corruption faults, checked against a March C- reference model.
module tb_sram_march_bist_ctrl;
    localparam int DA = 256;
    localparam int DB = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    always #5 clk = ~clk;

    logic       busy_a, done_a, pass_a, fail_a, en_a, men_a, wen_a, ren_a;
    logic [7:0] faddr_a, fbits_a, fcnt_a, addr_a, din_a, bm_a, dout_a;
    logic [2:0] felem_a;
    logic [1:0] st_a;
    logic       busy_b, done_b, pass_b, fail_b, en_b, men_b, wen_b, ren_b;
    logic [7:0] faddr_b, fbits_b, fcnt_b, addr_b, din_b, bm_b, dout_b;
    logic [2:0] felem_b;
    logic [1:0] st_b;
    logic       start_a, start_b;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    sram_march_bist_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(DA)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .pass_o(pass_a), .fail_o(fail_a), .fail_addr_o(faddr_a), .fail_elem_o(felem_a),
        .fail_bits_o(fbits_a), .fail_cnt_o(fcnt_a), .bist_en_o(en_a), .bist_men_o(men_a),
        .bist_wen_o(wen_a), .bist_ren_o(ren_a), .bist_addr_o(addr_a), .bist_din_o(din_a),
        .bist_bm_o(bm_a), .bist_dout_i(dout_a), .dbg_state_o(st_a)
    );

    sram_march_bist_ctrl #(.ADDR_W(8), .DATA_W(8), .DEPTH(DB)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .pass_o(pass_b), .fail_o(fail_b), .fail_addr_o(faddr_b), .fail_elem_o(felem_b),
        .fail_bits_o(fbits_b), .fail_cnt_o(fcnt_b), .bist_en_o(en_b), .bist_men_o(men_b),
        .bist_wen_o(wen_b), .bist_ren_o(ren_b), .bist_addr_o(addr_b), .bist_din_o(din_b),
        .bist_bm_o(bm_b), .bist_dout_i(dout_b), .dbg_state_o(st_b)
    );

    // Behavioural macros: synchronous read, bit-masked write; A carries the fault masks.
    logic [7:0] mem_a[DA];
    logic [7:0] mem_b[DB];
    logic [7:0] s0[DA];
    logic [7:0] s1[DA];
    int corrupt_n = 0;
    int rd_n_a = 0;

    always @(posedge clk) begin
        if (start_a && !busy_a) rd_n_a <= 0;
        if (men_a && ren_a) begin
            rd_n_a <= rd_n_a + 1;
            dout_a <= (rd_n_a + 1 == corrupt_n) ? 8'hFF
                    : ((mem_a[addr_a] & ~s0[addr_a]) | s1[addr_a]);
        end
        if (men_a && wen_a) mem_a[addr_a] <= (mem_a[addr_a] & ~bm_a) | (din_a & bm_a);
    end

    always @(posedge clk) begin
        if (men_b && ren_b) dout_b <= (int'(addr_b) < DB) ? mem_b[addr_b] : 8'h00;
        if (men_b && wen_b && int'(addr_b) < DB) mem_b[addr_b] <= (mem_b[addr_b] & ~bm_b) | (din_b & bm_b);
    end

    logic       o_busy, o_done, o_en, o_men, o_wen, o_ren;
    logic [7:0] o_addr, o_din, o_bm;
    assign o_busy = sel ? busy_b : busy_a;
    assign o_done = sel ? done_b : done_a;
    assign o_en   = sel ? en_b   : en_a;
    assign o_men  = sel ? men_b  : men_a;
    assign o_wen  = sel ? wen_b  : wen_a;
    assign o_ren  = sel ? ren_b  : ren_a;
    assign o_addr = sel ? addr_b : addr_a;
    assign o_din  = sel ? din_b  : din_a;
    assign o_bm   = sel ? bm_b   : bm_a;

    logic [58:0] outs_a, outs_b;
    assign outs_a = {busy_a, done_a, pass_a, fail_a, faddr_a, felem_a, fbits_a, fcnt_a,
                     en_a, men_a, wen_a, ren_a, addr_a, din_a, bm_a};
    assign outs_b = {busy_b, done_b, pass_b, fail_b, faddr_b, felem_b, fbits_b, fcnt_b,
                     en_b, men_b, wen_b, ren_b, addr_b, din_b, bm_b};

    // Scoreboard: ops are {we, addr, din}.
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];
    int         m_cnt;
    logic [7:0] m_addr, m_bits;
    logic [2:0] m_elem;
    int checks = 0;
    int errors = 0;

    // March C- written out element by element, with the expected fault outcome.
    task automatic build_model(input int depth);
        int a, nrd;
        logic [7:0] rbg, wbg, obs;
        exp_q.delete();
        m_cnt = 0; m_addr = 0; m_bits = 0; m_elem = 0; nrd = 0;
        for (int e = 0; e < 6; e++) begin
            rbg = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            wbg = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            for (int k = 0; k < depth; k++) begin
                a = (e == 3 || e == 4) ? depth - 1 - k : k;
                if (e != 0) begin
                    exp_q.push_back({1'b0, 8'(a), 8'h00});
                    nrd++;
                    obs = (nrd == corrupt_n) ? 8'hFF : ((rbg & ~s0[a]) | s1[a]);
                    if (obs != rbg) begin
                        if (m_cnt == 0) begin
                            m_addr = 8'(a); m_elem = 3'(e); m_bits = obs ^ rbg;
                        end
                        if (m_cnt < 255) m_cnt++;
                    end
                end
                if (e != 5) exp_q.push_back({1'b1, 8'(a), wbg});
            end
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DA; i++) begin
            s0[i] = 8'h00;
            s1[i] = 8'h00;
        end
        corrupt_n = 0;
    endtask

    function automatic int first_diff();
        if (obs_q.size() != exp_q.size()) return -2;
        foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // One complete run on the selected instance; cycle 1 is the first cycle after the start edge.
    task automatic run_test(input bit hold, output int done_at, output int pin_errs);
        int n;
        bit seen;
        obs_q.delete();
        pin_errs = 0; done_at = -1; seen = 0; n = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        while (!seen && n < 12 * DA) begin
            @(negedge clk); n++;
            if (o_ren || o_wen) obs_q.push_back({o_wen, o_addr, o_din});
            if (!o_en || !o_busy || o_bm !== 8'hFF || (o_ren && o_wen) || o_men !== (o_ren | o_wen))
                pin_errs++;
            if (o_done) begin seen = 1; done_at = n; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs_a !== '0) begin errors++; $display("FAIL reset_a: got %h want 0", outs_a); end
        checks++;
        if (outs_b !== '0) begin errors++; $display("FAIL reset_b: got %h want 0", outs_b); end
        rst = 1'b0;
    endtask

    task automatic check_run(input string name, input int done_at, input int exp_done, input int pin_errs);
        int d;
        d = first_diff();
        checks++;
        if (done_at != exp_done) begin errors++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_at, exp_done); end
        checks++;
        if (d != -1) begin errors++; $display("FAIL %s op_seq: first diff %0d, got %0d ops want %0d", name, d, obs_q.size(), exp_q.size()); end
        checks++;
        if (pin_errs != 0) begin errors++; $display("FAIL %s pin_ctrl: got %0d bad cycles want 0", name, pin_errs); end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_en !== 1'b0 || o_done !== 1'b0) begin
            errors++; $display("FAIL %s post_done: busy %b en %b done %b want 000", name, o_busy, o_en, o_done);
        end
    endtask

    task automatic check_diag(input string name);
        checks++;
        if ({pass_a, fail_a} !== {m_cnt == 0, m_cnt != 0}) begin
            errors++; $display("FAIL %s pass_fail: got %b%b want %b%b", name, pass_a, fail_a, m_cnt == 0, m_cnt != 0);
        end
        checks++;
        if ({faddr_a, felem_a, fbits_a, fcnt_a} !== {m_addr, m_elem, m_bits, 8'(m_cnt)}) begin
            errors++; $display("FAIL %s diag: got addr %h elem %0d bits %h cnt %0d want addr %h elem %0d bits %h cnt %0d",
                name, faddr_a, felem_a, fbits_a, fcnt_a, m_addr, m_elem, m_bits, m_cnt);
        end
    endtask

    task automatic test_fault_free();
        int done_at, pe, nr, nw;
        clear_faults();
        build_model(DA);
        run_test(1'b0, done_at, pe);
        nr = 0; nw = 0;
        foreach (obs_q[i]) if (obs_q[i][16]) nw++; else nr++;
        checks++;
        if (nr != 1280 || nw != 1280) begin errors++; $display("FAIL ff_counts: got r%0d w%0d want r1280 w1280", nr, nw); end
        checks++;
        if ({pass_a, fail_a, fcnt_a} !== {1'b1, 1'b0, 8'd0}) begin
            errors++; $display("FAIL ff_result: got pass %b fail %b cnt %0d want 1 0 0", pass_a, fail_a, fcnt_a);
        end
        check_run("fault_free", done_at, 2562, pe);
    endtask

    task automatic test_stuck_5a();
        int done_at, pe;
        clear_faults();
        s1[8'h5A] = 8'h08;
        build_model(DA);
        run_test(1'b0, done_at, pe);
        checks++;
        if ({fail_a, pass_a, faddr_a, felem_a, fbits_a, fcnt_a} !== {1'b1, 1'b0, 8'h5A, 3'd1, 8'h08, 8'd3}) begin
            errors++; $display("FAIL stuck_5a: got fail %b addr %h elem %0d bits %h cnt %0d want 1 5a 1 08 3",
                fail_a, faddr_a, felem_a, fbits_a, fcnt_a);
        end
        check_run("stuck_5a", done_at, 2562, pe);
    endtask

    task automatic test_random_faults();
        int done_at, pe, nf, a;
        for (int it = 0; it < 3; it++) begin
            clear_faults();
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(0, DA - 1);
                if ($urandom_range(0, 1) == 1) s1[a] = 8'(1 << $urandom_range(0, 7)) | 8'($urandom_range(0, 255));
                else s0[a] = 8'(1 << $urandom_range(0, 7));
            end
            build_model(DA);
            run_test(1'b0, done_at, pe);
            check_diag("random_fault");
            check_run("random_fault", done_at, 2562, pe);
        end
    endtask

    task automatic test_drain_corrupt();
        int done_at, pe;
        clear_faults();
        corrupt_n = 1280;
        build_model(DA);
        run_test(1'b0, done_at, pe);
        checks++;
        if ({fail_a, faddr_a, felem_a, fbits_a, fcnt_a} !== {1'b1, 8'hFF, 3'd5, 8'hFF, 8'd1}) begin
            errors++; $display("FAIL drain_corrupt: got fail %b addr %h elem %0d bits %h cnt %0d want 1 ff 5 ff 1",
                fail_a, faddr_a, felem_a, fbits_a, fcnt_a);
        end
        check_diag("drain_corrupt");
        corrupt_n = 0;
    endtask

    task automatic test_hold_start();
        int done_at, pe, extra;
        clear_faults();
        build_model(DA);
        run_test(1'b1, done_at, pe);
        check_run("hold_start", done_at, 2562, pe);
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_a || busy_a) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL hold_start_rerun: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_midrun();
        int done_at, pe;
        clear_faults();
        s1[$urandom_range(0, 63)] = 8'(1 << $urandom_range(0, 7));
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (700) @(negedge clk);
        checks++;
        if (fcnt_a !== 8'd1) begin errors++; $display("FAIL midrun_cnt: got %0d want 1", fcnt_a); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (outs_a !== '0) begin errors++; $display("FAIL midrun_reset: got %h want 0", outs_a); end
        rst = 1'b0;
        clear_faults();
        build_model(DA);
        run_test(1'b0, done_at, pe);
        check_diag("restart");
        check_run("restart", done_at, 2562, pe);
    endtask

    task automatic test_depth5();
        int done_at, pe;
        clear_faults();
        sel = 1'b1;
        build_model(DB);
        run_test(1'b0, done_at, pe);
        checks++;
        if ({pass_b, fail_b, fcnt_b} !== {1'b1, 1'b0, 8'd0}) begin
            errors++; $display("FAIL depth5_result: got pass %b fail %b cnt %0d want 1 0 0", pass_b, fail_b, fcnt_b);
        end
        check_run("depth5", done_at, 52, pe);
        sel = 1'b0;
    endtask

    initial begin
        clear_faults();
        test_reset();
        test_fault_free();
        test_stuck_5a();
        test_random_faults();
        test_drain_corrupt();
        test_hold_start();
        test_reset_midrun();
        test_depth5();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_march_bist_ctrl.md
# sram_march_bist_ctrl

March C- built-in self-test controller for the single-port SG13G2 SRAM macros that have a BIST port (for example, the 256x8 byte-mask variant). It sits directly upstream of the macro and drives its BIST_* inputs: enable, memory enable, write enable, read enable, address, data-in and byte mask. It consumes the macro's DOUT, compares every read against the expected background, and reports pass or fail with first-failure diagnostics to the test/DFT controller.

## Interface
- ADDR_W, 8, macro address width
- DATA_W, 8, macro data width
- DEPTH, 256, number of words tested (addresses 0..DEPTH-1); 2 <= DEPTH <= 2**ADDR_W
- clk_i  in  1  controller clock; it must be the same net as the macro BIST clock
- rst_i  in  1  reset, synchronous and active-high
- start_i  in  1  begin a test run; sampled only in IDLE
- busy_o  out  1  high from the cycle after start is accepted through the DONE cycle
- done_o  out  1  one-cycle pulse at the end of the run
- pass_o  out  1  sticky: the last run completed with no miscompare
- fail_o  out  1  sticky: the last run had at least one miscompare
- fail_addr_o  out  ADDR_W  address of the first miscompare
- fail_elem_o  out  3  March element index (0..5) of the first miscompare
- fail_bits_o  out  DATA_W  XOR of read and expected data at the first miscompare
- fail_cnt_o  out  8  number of miscompares, saturating at 255
- bist_en_o  out  1  selects the macro BIST port
- bist_men_o, bist_wen_o, bist_ren_o  out  1 each  macro BIST enables
- bist_addr_o  out  ADDR_W  macro BIST address
- bist_din_o  out  DATA_W  macro BIST write data
- bist_bm_o  out  DATA_W  macro BIST bit mask; all ones while bist_en_o is high, otherwise 0
- bist_dout_i  in  DATA_W  macro DOUT

## Operation
- The algorithm is March C-, six elements:
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
- Data encoding: "0" is all-zeros, "1" is all-ones over DATA_W bits.
- Address direction:
  - ⇑ runs 0 to DEPTH-1.
  - ⇓ runs DEPTH-1 to 0.
  - The address counter reloads at each element boundary; it never wraps inside an element.
- In E1–E4 each address gets one read cycle followed by one write cycle to the same address. The address advances only after the write.
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE to RUN on start_i=1.
  - RUN to DRAIN after the last E5 read is issued.
  - DRAIN to DONE unconditionally.
  - DONE to IDLE unconditionally.
- Each RUN cycle issues exactly one operation:
  - Common to both: men=1, en=1, bm=all ones.
  - Write: wen=1, ren=0, din = background.
  - Read: ren=1, wen=0, din=0.
- Compare pipeline:
  - Each read registers expected data, address, element and a valid flag.
  - On the following cycle, bist_dout_i is compared against the registered expected value, and the result is latched at the next edge.
- Miscompare handling:
  - The first miscompare latches fail_addr, fail_elem and fail_bits.
  - Later miscompares only increment fail_cnt_o.
  - The test always runs to completion; there is no stop-on-fail.
- On start:
  - fail_addr, fail_elem, fail_bits, fail_cnt, pass_o and fail_o are cleared.
  - In DONE, exactly one of pass_o or fail_o is set, and both hold until the next start.
- start_i is ignored when the FSM is not in IDLE, including in DONE.
- Reset at any point, including mid-run:
  - The FSM returns to IDLE.
  - All outputs go to 0 at the next edge.
  - The compare-valid flag is cleared, so no spurious fail is recorded.
  - Memory contents are undefined afterwards; a new start reruns the full test.

## Timing
- Reset value of every output is 0.
- Start accepted at edge 0:
  - RUN cycles 1..10*DEPTH, giving 2560 cycles for DEPTH=256.
  - DRAIN at cycle 10*DEPTH+1, which resolves the final E5 compare.
  - DONE at 10*DEPTH+2: done_o=1, and pass_o/fail_o are valid from this cycle.
  - busy_o=0 and state IDLE at 10*DEPTH+3.
- The macro read is synchronous: DOUT is valid in the cycle after the read edge. The compare uses exactly that cycle.
- In E1–E4, the write issued on the cycle after a read does not disturb the compare. DOUT is sampled at the same edge that launches the write.
- bist_* outputs:
  - They come directly from registers, with no combinational path from inputs.
  - bist_en_o is high from cycle 1 through DONE; the macro's BIST enable has no setup/hold arc.
  - bist_men_o, bist_wen_o and bist_ren_o are 0 in DRAIN and DONE.
- fail_cnt_o increments one cycle after the offending compare cycle and saturates at 255.

## Test plan
- Fault-free 256x8 macro model, start pulse at edge 0:
  - done_o=1 at cycle 2562.
  - pass_o=1, fail_o=0, fail_cnt_o=0.
  - 1280 reads and 1280 writes are observed, with the address sequence checked per element.
- Bit 3 of address 0x5A stuck-at-1:
  - First failure is in E1 (r0): fail_addr_o=0x5A, fail_elem_o=1, fail_bits_o=0x08.
  - Further failures occur in E3 (r0) and E5 (r0), so fail_cnt_o=3 and fail_o=1.
- DEPTH=5 instance:
  - E3 and E4 addresses run 4,4,3,3,...,0,0, with address 5 never driven.
  - done_o at cycle 52.
- start_i held high for the whole run and into DONE: exactly one run executes, and done_o pulses once.
- rst_i asserted at RUN cycle 700 while a fault is injected before that cycle:
  - All outputs are 0 at the next edge, with fail_o=0.
  - A restart completes normally at cycle 2562 relative to its own start.
- DOUT corrupted to 0xFF only during the DRAIN compare, i.e. the last E5 read at address 255: fail_o=1, fail_addr_o=0xFF, fail_elem_o=5, fail_cnt_o=1.
